counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Run-control sequencer for the synchronous up-counter datapath. Captures a terminal
//  count on start, advances an internal counter core, and supports pause, abort and
//  auto-reload (periodic) modes. Emits a one-cycle done pulse at terminal. Sits between
//  control logic and timing consumers as the shared interval/tick generator.
// PARAMETERS
//  WIDTH       4  counter and limit width in bits
//  PRESCALE_W  4  prescaler width; used only when COUNTER_SEQ_PRESCALE_EN is defined
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           reset: synchronous, active-high
//  start        in   1           start pulse; sampled in IDLE only
//  stop         in   1           abort run; returns to IDLE without done
//  pause        in   1           level: hold count while high
//  auto_reload  in   1           1 = periodic; sampled on the terminal cycle
//  limit        in   WIDTH       terminal count; captured on accepted start
//  count        out  WIDTH       current count value
//  busy         out  1           high in RUN or PAUSE
//  done         out  1           one-cycle pulse while count == captured limit
//  state        out  2           IDLE=0, RUN=1, PAUSE=2
// BEHAVIOUR
//  - Reset: state=IDLE, count=0, busy=0, done=0, limit_q=0. rst overrides everything.
//  - Priority per cycle: rst > stop > pause > advance. start is ignored unless IDLE.
//  - IDLE + start (stop=0): limit_q<=limit, count<=0, state<=RUN. With start and stop
//    in the same cycle, stop wins and the block stays IDLE.
//  - IDLE + start with limit==0: stay IDLE, count=0, done=1 for the next cycle only.
//  - RUN, pause=0: count<=count+1 on each advance.
//    Count reaches 1 one cycle after the start edge.
//  - Terminal: an advance from count==limit_q-1 sets count<=limit_q and done<=1
//    (registered), so done is high in the cycle where count==limit_q.
//    * auto_reload=1: next advance sets count<=0 and the block stays in RUN.
//      Period = limit_q+1 advances.
//    * auto_reload=0: state<=IDLE, count holds limit_q, busy<=0 in the same edge
//      that sets done.
//  - The counter never exceeds limit_q. No wrap past 2^WIDTH-1; limit=all-ones is legal.
//  - RUN + pause=1: state<=PAUSE and count holds. PAUSE + pause=0: return to RUN.
//    Advances resume the next cycle.
//  - stop in RUN or PAUSE: state<=IDLE, count holds, done stays 0.
//  - done is never high for two consecutive cycles, except in auto_reload with
//    limit_q==0, where done is held high continuously.
//  - rst asserted mid-run: all outputs return to reset values at the next edge.
// CONFIGURATION
//  COUNTER_SEQ_PRESCALE_EN defined:
//    - Adds input port prescale [PRESCALE_W-1:0].
//    - An advance occurs only on prescaler terminal: once every prescale+1 cycles.
//    - The prescaler clears on start, stop and rst, and freezes in PAUSE.
//  COUNTER_SEQ_PRESCALE_EN undefined:
//    - No prescale port. An advance occurs every RUN cycle.
// STRUCTURE
//  - Shared package/header counter_seq_pkg holds:
//    * state localparams S_IDLE/S_RUN/S_PAUSE
//    * state width constant (2)
//  - Sub-module up_counter_core (WIDTH): synchronous clear, load-zero, enable-increment.
//    The sequencer's FSM drives its clear/enable pins.
// TESTING
//  - rst=1 for 2 cycles -> count=0, busy=0, done=0, state=0.
//  - limit=5, start pulse, auto_reload=0 -> count 1..5 on successive cycles;
//    done=1 exactly when count=5; busy falls with it; count holds 5.
//  - limit=3, auto_reload=1, run 12 cycles -> count 0,1,2,3 repeating; done every
//    4th cycle; busy stays 1.
//  - limit=10, pause high for 4 cycles at count=4 -> state=2 and count holds 4;
//    resumes at 5; done arrives 4 cycles late.
//  - stop at count=6 of limit 9 -> state=0, count=6, no done. start+stop together in
//    IDLE -> stays IDLE.
//  - limit=0 start -> single done pulse, busy never rises. With the macro defined and
//    prescale=2, limit=2 -> done 6 cycles after start.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: run-state encoding and its width.
// Optional prescaler is enabled by defining COUNTER_SEQ_PRESCALE_EN.
package counter_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/up_counter_core.sv
// Synchronous up-counter datapath: clear (load zero) has priority over increment.
module up_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control sequencer around up_counter_core: start/stop/pause, auto-reload, done pulse.
// Define COUNTER_SEQ_PRESCALE_EN to add the prescale port and slow the advance rate.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  auto_reload,
`ifdef COUNTER_SEQ_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    input  logic [WIDTH-1:0]      limit,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic [STATE_W-1:0]    state
);

    seq_state_t       state_q, next_state;
    logic [WIDTH-1:0] limit_q;
    logic             next_done;
    logic             load_limit;
    logic             ctr_clear;
    logic             ctr_enable;
    logic             pre_clear;
    logic             pre_run;
    logic             tick;
    logic [WIDTH:0]   count_plus;

    assign count_plus = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [PRESCALE_W-1:0] pre_q;
    localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    assign tick = (pre_q == prescale);

    // Prescaler only counts while actively running; it holds through PAUSE.
    always_ff @(posedge clk) begin
        if (rst || pre_clear) begin
            pre_q <= '0;
        end else if (pre_run) begin
            pre_q <= tick ? '0 : pre_q + PRE_ONE;
        end
    end
`else
    logic [PRESCALE_W-1:0] unused_prescale;
    logic                  unused_pre_ctl;

    assign unused_prescale = '0;
    assign unused_pre_ctl  = pre_clear ^ pre_run;
    assign tick            = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            limit_q <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= next_state;
            done    <= next_done;
            if (load_limit) begin
                limit_q <= limit;
            end
        end
    end

    always_comb begin
        next_state = state_q;
        next_done  = 1'b0;
        load_limit = 1'b0;
        ctr_clear  = 1'b0;
        ctr_enable = 1'b0;
        pre_clear  = 1'b0;
        pre_run    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    load_limit = 1'b1;
                    ctr_clear  = 1'b1;
                    pre_clear  = 1'b1;
                    if (limit == '0) begin
                        next_done = 1'b1;
                    end else begin
                        next_state = S_RUN;
                    end
                end
            end
            S_RUN, S_PAUSE: begin
                if (stop) begin
                    next_state = S_IDLE;
                    pre_clear  = 1'b1;
                end else if (pause) begin
                    next_state = S_PAUSE;
                end else begin
                    next_state = S_RUN;
                    pre_run    = 1'b1;
                    if (tick) begin
                        // Sitting at the limit only happens after an auto-reload terminal.
                        if (count == limit_q) begin
                            ctr_clear = 1'b1;
                            next_done = (limit_q == '0);
                        end else begin
                            ctr_enable = 1'b1;
                            if (count_plus == {1'b0, limit_q}) begin
                                next_done = 1'b1;
                                if (!auto_reload) begin
                                    next_state = S_IDLE;
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    up_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clear (ctr_clear),
        .enable(ctr_enable),
        .count (count)
    );

    assign busy  = (state_q != S_IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer; covers the COUNTER_SEQ_PRESCALE_EN build when defined.
module tb_counter_sequencer;

    typedef struct {
        logic [3:0] count;
        logic       busy;
        logic       done;
        logic [1:0] state;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] limit = 4'd0;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [1:0] state;
`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [3:0] prescale = 4'd0;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    counter_sequencer #(
        .WIDTH(4),
        .PRESCALE_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .auto_reload(auto_reload),
`ifdef COUNTER_SEQ_PRESCALE_EN
        .prescale   (prescale),
`endif
        .limit      (limit),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic applyStimulus(input logic r, input logic st, input logic sp,
                                 input logic pa, input logic ar, input logic [3:0] lim,
                                 input logic [3:0] ec, input logic eb, input logic ed,
                                 input logic [1:0] es, input string nm);
        exp_t e;
        @(negedge clk);
        rst         = r;
        start       = st;
        stop        = sp;
        pause       = pa;
        auto_reload = ar;
        limit       = lim;
        e.count = ec;
        e.busy  = eb;
        e.done  = ed;
        e.state = es;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (count !== e.count || busy !== e.busy || done !== e.done || state !== e.state) begin
            errors++;
            $display("[TB] FAIL %s: got count=%0d busy=%b done=%b state=%0d, want count=%0d busy=%b done=%b state=%0d",
                     e.name, count, busy, done, state, e.count, e.busy, e.done, e.state);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        // reset
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");

        // single run to 5
        applyStimulus(0, 1, 0, 0, 0, 5, 0, 1, 0, 1, "l5_start");
        for (int i = 1; i <= 4; i++)
            applyStimulus(0, 0, 0, 0, 0, 5, 4'(i), 1, 0, 1, "l5_count");
        applyStimulus(0, 0, 0, 0, 0, 5, 5, 0, 1, 0, "l5_done");
        applyStimulus(0, 0, 0, 0, 0, 5, 5, 0, 0, 0, "l5_hold");

        // auto-reload with limit 3
        applyStimulus(0, 1, 0, 0, 1, 3, 0, 1, 0, 1, "ar_start");
        for (int i = 0; i < 12; i++)
            applyStimulus(0, 0, 0, 0, 1, 3, 4'((i + 1) % 4), 1, ((i % 4) == 2), 1, "ar_cycle");
        applyStimulus(0, 0, 1, 0, 1, 3, 0, 0, 0, 0, "ar_stop");

        // pause at count 4 of limit 10
        applyStimulus(0, 1, 0, 0, 0, 10, 0, 1, 0, 1, "p_start");
        for (int i = 1; i <= 4; i++)
            applyStimulus(0, 0, 0, 0, 0, 10, 4'(i), 1, 0, 1, "p_count");
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 0, 1, 0, 10, 4, 1, 0, 2, "p_hold");
        for (int i = 5; i <= 9; i++)
            applyStimulus(0, 0, 0, 0, 0, 10, 4'(i), 1, 0, 1, "p_resume");
        applyStimulus(0, 0, 0, 0, 0, 10, 10, 0, 1, 0, "p_done");

        // stop at count 6 of limit 9, then start+stop in IDLE
        applyStimulus(0, 1, 0, 0, 0, 9, 0, 1, 0, 1, "s_start");
        for (int i = 1; i <= 6; i++)
            applyStimulus(0, 0, 0, 0, 0, 9, 4'(i), 1, 0, 1, "s_count");
        applyStimulus(0, 0, 1, 0, 0, 9, 6, 0, 0, 0, "s_stop");
        applyStimulus(0, 0, 0, 0, 0, 9, 6, 0, 0, 0, "s_idle");
        applyStimulus(0, 1, 1, 0, 0, 9, 6, 0, 0, 0, "s_start_stop");
        applyStimulus(0, 0, 0, 0, 0, 9, 6, 0, 0, 0, "s_still_idle");

        // zero limit: single done pulse, never busy
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "z_start");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "z_after");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "z_quiet");

        // reset in mid-run
        applyStimulus(0, 1, 0, 0, 0, 15, 0, 1, 0, 1, "r_start");
        for (int i = 1; i <= 3; i++)
            applyStimulus(0, 0, 0, 0, 0, 15, 4'(i), 1, 0, 1, "r_count");
        applyStimulus(1, 0, 0, 0, 0, 15, 0, 0, 0, 0, "r_reset");
        applyStimulus(0, 0, 0, 0, 0, 15, 0, 0, 0, 0, "r_after");

        // all-ones limit without wrap
        applyStimulus(0, 1, 0, 0, 0, 15, 0, 1, 0, 1, "f_start");
        for (int i = 1; i <= 15; i++)
            applyStimulus(0, 0, 0, 0, 0, 15, 4'(i), (i != 15), (i == 15),
                          (i == 15) ? 2'd0 : 2'd1, "f_count");
        applyStimulus(0, 0, 0, 0, 0, 15, 15, 0, 0, 0, "f_hold");

`ifdef COUNTER_SEQ_PRESCALE_EN
        // prescale 2, limit 2: one advance every three cycles
        @(negedge clk);
        prescale = 4'd2;
        applyStimulus(0, 1, 0, 0, 0, 2, 0, 1, 0, 1, "ps_start");
        applyStimulus(0, 0, 0, 0, 0, 2, 0, 1, 0, 1, "ps_wait1");
        applyStimulus(0, 0, 0, 0, 0, 2, 0, 1, 0, 1, "ps_wait2");
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 1, 0, 1, "ps_adv1");
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 1, 0, 1, "ps_wait3");
        applyStimulus(0, 0, 0, 0, 0, 2, 1, 1, 0, 1, "ps_wait4");
        applyStimulus(0, 0, 0, 0, 0, 2, 2, 0, 1, 0, "ps_done");
`endif

        // let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
